traceback_unit: RTL and testbench
=================================

TRACEBACK_UNIT -- requirements
Module: traceback_unit

Interface
REQ-001 SHALL have parameter TB_LEN, default 32, meaning total traceback stages per run (>= DEC_LEN+1).
REQ-002 SHALL have parameter DEC_LEN, default 8, meaning decoded bits emitted per run (1..16).
REQ-003 SHALL have port CLOCK  in  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port Reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port Start  in  1  request a traceback run; sampled only in IDLE.
REQ-006 SHALL have port StartState  in  6  best-metric state from the ACS unit, sampled with Start.
REQ-007 SHALL have port DataTB  in  8  survivor word from the memory manager, valid the cycle after RdEn.
REQ-008 SHALL have port AddressTB  out  3  survivor word index within the current traceback page.
REQ-009 SHALL have port RdEn  out  1  read strobe to the memory manager.
REQ-010 SHALL have port TBInit  out  1  one-cycle pulse on run start; the memory manager loads its traceback page from it.
REQ-011 SHALL have ports DecodedBit and DecodedValid  out  1 each  decoded output bit and its qualifier.
REQ-012 SHALL have ports Busy and Done  out  1 each  run in progress; one-cycle run-complete pulse.

Function
REQ-013 SHALL implement FSM IDLE -> READ -> UPDATE -> (READ | DRAIN | IDLE); DRAIN exists only with TB_LIFO_EN.
REQ-014 IDLE: Start=1 loads state register with StartState, clears stage counter, pulses TBInit, goes to READ next cycle.
REQ-015 READ: RdEn=1, AddressTB=state[5:3]; always to UPDATE.
REQ-016 UPDATE: survivor s = DataTB[state[2:0]]; decoded bit d = state[0]; state <= {s, state[5:1]}; counter increments.
REQ-017 UPDATE of stages TB_LEN-DEC_LEN..TB_LEN-1 (counter value) SHALL produce d; earlier stages produce nothing.
REQ-018 After UPDATE of stage TB_LEN-1: DRAIN with TB_LIFO_EN, IDLE without; otherwise READ.
REQ-019 Every traceback stage SHALL take exactly 2 cycles; RdEn is never high in two consecutive cycles.
REQ-020 Busy SHALL be 1 in every non-IDLE state, 0 in IDLE.
REQ-021 Start while Busy=1 SHALL be ignored with no queueing; Start in the cycle Done=1 (IDLE) SHALL be accepted.
REQ-022 DecodedBit/DecodedValid SHALL be registered; DecodedBit holds its last value while DecodedValid=0.
REQ-023 Done SHALL pulse in the same cycle as the last DecodedValid of a run.
REQ-024 Stage counter SHALL be ceil(log2(TB_LEN+1)) bits and never wrap within a run.

Reset
REQ-025 Reset=1 SHALL force IDLE, clear state register, counter and LIFO, and drive all outputs to 0 at any time, including mid-run.
REQ-026 After Reset deasserts, no DecodedValid SHALL occur until a new Start is accepted.

Configuration
REQ-027 Macro TRACEBACK_UNIT_TB_LIFO_EN defined: decoded bits are pushed into a DEC_LEN-deep LIFO; DRAIN pops one per cycle for DEC_LEN cycles, giving chronological order (oldest first); Busy spans 2*TB_LEN+DEC_LEN cycles.
REQ-028 Macro undefined: each decoded bit appears on DecodedBit/DecodedValid the cycle after its UPDATE, in traceback (newest-first) order; no LIFO logic present; Busy spans 2*TB_LEN cycles.
REQ-029 LIFO push with LIFO full, or pop with LIFO empty, SHALL be impossible by construction; an assertion SHALL flag either.

Structure
REQ-030 Shared package tb_pkg SHALL hold WD_STATE=6, WD_TB_ADDRESS=3, WD_RAM_DATA=8, and the FSM state encoding.
REQ-031 LIFO SHALL be sub-module tb_lifo (push, pop, clear, data in/out, empty/full), instantiated only under TRACEBACK_UNIT_TB_LIFO_EN.

Verification
REQ-032 DataTB=8'h00 constant, StartState=6'h00 -> DEC_LEN bits all 0, Done after the last; AddressTB=0 throughout.
REQ-033 DataTB=8'hFF constant, StartState=6'h3F -> all decoded bits 1; state stays 6'h3F.
REQ-034 StartState=6'h01, DataTB=8'h00, TB_LEN=8, DEC_LEN=2 -> state walks 01,00,...; decoded bits (stages 6,7) both 0; first UPDATE decodes 1 but emits nothing.
REQ-035 Start held high for whole run -> exactly one TBInit and one Done; restart accepted in the Done cycle.
REQ-036 Reset pulsed during stage 10 -> all outputs 0 next cycle, no further DecodedValid until next Start.
REQ-037 Both macro settings, DataTB driven from a model with known encoder input 8'b1011_0010 -> output order matches REQ-027/REQ-028; Busy length checked exactly.

Source files
------------

// File: rtl/tb_pkg.sv
// Shared widths and FSM encoding for the Viterbi traceback unit.
// Imported by traceback_unit and tb_lifo.
package tb_pkg;
    localparam int WD_STATE      = 6;
    localparam int WD_TB_ADDRESS = 3;
    localparam int WD_RAM_DATA   = 8;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_READ   = 2'd1,
        S_UPDATE = 2'd2,
        S_DRAIN  = 2'd3
    } tbState_t;
endpackage

// File: rtl/traceback_unit_lifo.sv
// Bit-wide LIFO that reverses traceback order into chronological order.
// Used by traceback_unit only when TRACEBACK_UNIT_TB_LIFO_EN is defined.
module tb_lifo
    import tb_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic CLOCK,
    input  logic Reset,
    input  logic push,
    input  logic pop,
    input  logic clear,
    input  logic dataIn,
    output logic dataOut,
    output logic empty,
    output logic full
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] mem;
    logic [CW-1:0]    count;

    // Top of stack always sits in mem[0]; push shifts up, pop shifts down.
    always_ff @(posedge CLOCK or posedge Reset) begin
        if (Reset) begin
            mem   <= '0;
            count <= '0;
        end else if (clear) begin
            mem   <= '0;
            count <= '0;
        end else if (push) begin
            mem   <= DEPTH'({mem, dataIn});
            count <= count + CW'(1);
        end else if (pop) begin
            mem   <= mem >> 1;
            count <= count - CW'(1);
        end
    end

    assign dataOut = mem[0];
    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
endmodule

// File: rtl/traceback_unit.sv
// Viterbi traceback: walks survivor memory back TB_LEN stages per run.
// TRACEBACK_UNIT_TB_LIFO_EN reorders decoded bits oldest-first.
module traceback_unit
    import tb_pkg::*;
#(
    parameter int TB_LEN  = 32,
    parameter int DEC_LEN = 8
) (
    input  logic                     CLOCK,
    input  logic                     Reset,
    input  logic                     Start,
    input  logic [WD_STATE-1:0]      StartState,
    input  logic [WD_RAM_DATA-1:0]   DataTB,
    output logic [WD_TB_ADDRESS-1:0] AddressTB,
    output logic                     RdEn,
    output logic                     TBInit,
    output logic                     DecodedBit,
    output logic                     DecodedValid,
    output logic                     Busy,
    output logic                     Done
);
    localparam int CNT_W = $clog2(TB_LEN + 1);
    localparam logic [CNT_W-1:0] FIRST_EMIT = CNT_W'(TB_LEN - DEC_LEN);
    localparam logic [CNT_W-1:0] LAST_STAGE = CNT_W'(TB_LEN - 1);
    localparam int AHI = WD_STATE - 1;
    localparam int ALO = WD_STATE - WD_TB_ADDRESS;

    tbState_t            fsm;
    logic [WD_STATE-1:0] stateReg;
    logic [WD_STATE-1:0] nextState;
    logic [CNT_W-1:0]    stageCnt;
    logic                survivor;
    logic                decBit;
    logic                emit;
    logic                lastStage;

    always_comb begin
        survivor  = DataTB[stateReg[2:0]];
        decBit    = stateReg[0];
        nextState = {survivor, stateReg[WD_STATE-1:1]};
        emit      = (stageCnt >= FIRST_EMIT);
        lastStage = (stageCnt == LAST_STAGE);
    end

`ifdef TRACEBACK_UNIT_TB_LIFO_EN
    localparam int DRN_W = $clog2(DEC_LEN + 1);
    localparam logic [DRN_W-1:0] LAST_DRAIN = DRN_W'(DEC_LEN - 1);

    logic [DRN_W-1:0] drainCnt;
    logic             lifoPush;
    logic             lifoPop;
    logic             lifoClear;
    logic             lifoOut;
    logic             lifoEmpty;
    logic             lifoFull;

    assign lifoPush  = (fsm == S_UPDATE) && emit;
    assign lifoPop   = (fsm == S_DRAIN);
    assign lifoClear = (fsm == S_IDLE) && Start;

    tb_lifo #(
        .DEPTH(DEC_LEN)
    ) uLifo (
        .CLOCK  (CLOCK),
        .Reset  (Reset),
        .push   (lifoPush),
        .pop    (lifoPop),
        .clear  (lifoClear),
        .dataIn (decBit),
        .dataOut(lifoOut),
        .empty  (lifoEmpty),
        .full   (lifoFull)
    );

    pushFull: assert property (@(posedge CLOCK) disable iff (Reset)
        !(lifoPush && lifoFull));
    popEmpty: assert property (@(posedge CLOCK) disable iff (Reset)
        !(lifoPop && lifoEmpty));
`endif

    always_ff @(posedge CLOCK or posedge Reset) begin
        if (Reset) begin
            fsm          <= S_IDLE;
            stateReg     <= '0;
            stageCnt     <= '0;
            AddressTB    <= '0;
            RdEn         <= 1'b0;
            TBInit       <= 1'b0;
            DecodedBit   <= 1'b0;
            DecodedValid <= 1'b0;
            Busy         <= 1'b0;
            Done         <= 1'b0;
`ifdef TRACEBACK_UNIT_TB_LIFO_EN
            drainCnt     <= '0;
`endif
        end else begin
            TBInit       <= 1'b0;
            RdEn         <= 1'b0;
            DecodedValid <= 1'b0;
            Done         <= 1'b0;
            unique case (fsm)
                S_IDLE: begin
                    if (Start) begin
                        stateReg  <= StartState;
                        stageCnt  <= '0;
                        TBInit    <= 1'b1;
                        RdEn      <= 1'b1;
                        AddressTB <= StartState[AHI:ALO];
                        Busy      <= 1'b1;
                        fsm       <= S_READ;
                    end
                end
                S_READ: begin
                    fsm <= S_UPDATE;
                end
                S_UPDATE: begin
                    stateReg <= nextState;
                    stageCnt <= stageCnt + CNT_W'(1);
`ifndef TRACEBACK_UNIT_TB_LIFO_EN
                    if (emit) begin
                        DecodedBit   <= decBit;
                        DecodedValid <= 1'b1;
                    end
`endif
                    if (lastStage) begin
`ifdef TRACEBACK_UNIT_TB_LIFO_EN
                        fsm      <= S_DRAIN;
                        drainCnt <= '0;
`else
                        fsm  <= S_IDLE;
                        Busy <= 1'b0;
                        Done <= 1'b1;
`endif
                    end else begin
                        fsm       <= S_READ;
                        RdEn      <= 1'b1;
                        AddressTB <= nextState[AHI:ALO];
                    end
                end
`ifdef TRACEBACK_UNIT_TB_LIFO_EN
                S_DRAIN: begin
                    DecodedBit   <= lifoOut;
                    DecodedValid <= 1'b1;
                    drainCnt     <= drainCnt + DRN_W'(1);
                    if (drainCnt == LAST_DRAIN) begin
                        fsm  <= S_IDLE;
                        Busy <= 1'b0;
                        Done <= 1'b1;
                    end
                end
`endif
                default: begin
                    fsm <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_traceback_unit.sv
// Self-checking bench for traceback_unit (both LIFO macro settings).
module tb_traceback_unit;
    localparam int TBL = 32;
    localparam int DL  = 8;
    localparam int TBS = 8;
    localparam int DLS = 2;
`ifdef TRACEBACK_UNIT_TB_LIFO_EN
    localparam bit LIFO = 1'b1;
`else
    localparam bit LIFO = 1'b0;
`endif
    localparam int BUSY_LEN  = LIFO ? 2*TBL + DL : 2*TBL;
    localparam int BUSY_S    = LIFO ? 2*TBS + DLS : 2*TBS;
    localparam int FIRST_V_S = LIFO ? 2*TBS + 1 : 2*(TBS - DLS) + 2;

    logic CLOCK = 1'b0;
    logic Reset = 1'b1;
    logic Start, RdEn, TBInit, DecodedBit, DecodedValid, Busy, Done;
    logic [5:0] StartState;
    logic [7:0] DataTB;
    logic [2:0] AddressTB;

    logic bStart, bRdEn, bTBInit, bBit, bValid, bBusy, bDone;
    logic [5:0] bStartState;
    logic [7:0] bDataTB;
    logic [2:0] bAddr;

    always #5 CLOCK = ~CLOCK;

    traceback_unit #(.TB_LEN(TBL), .DEC_LEN(DL)) dutA (
        .CLOCK(CLOCK), .Reset(Reset), .Start(Start),
        .StartState(StartState), .DataTB(DataTB),
        .AddressTB(AddressTB), .RdEn(RdEn), .TBInit(TBInit),
        .DecodedBit(DecodedBit), .DecodedValid(DecodedValid),
        .Busy(Busy), .Done(Done)
    );

    traceback_unit #(.TB_LEN(TBS), .DEC_LEN(DLS)) dutB (
        .CLOCK(CLOCK), .Reset(Reset), .Start(bStart),
        .StartState(bStartState), .DataTB(bDataTB),
        .AddressTB(bAddr), .RdEn(bRdEn), .TBInit(bTBInit),
        .DecodedBit(bBit), .DecodedValid(bValid),
        .Busy(bBusy), .Done(bDone)
    );

    typedef struct {
        logic [5:0] st;
        logic [7:0] data;
        logic [7:0] expTb;
        bit         hold;
    } vec_t;

    int nCmp = 0;
    int nBad = 0;
    logic [7:0] surv [TBL][8];
    logic [2:0] expAddr [TBL];
    bit mdl[$];
    bit expOut[$];

    task automatic cmp(input string nm, input int act, input int req);
        nCmp++;
        if (act != req) begin
            nBad++;
            $display("FAIL %s: got %0d required %0d", nm, act, req);
        end
    endtask

    // Reference traceback over the survivor table, plain arithmetic.
    function automatic void buildModel(input int st);
        int cur, s;
        cur = st;
        mdl.delete();
        for (int k = 0; k < TBL; k++) begin
            expAddr[k] = 3'(cur / 8);
            s = int'(surv[k][cur / 8][cur % 8]);
            if (k >= TBL - DL) mdl.push_back(bit'(cur % 2));
            cur = s * 32 + cur / 2;
        end
    endfunction

    function automatic void orderFromTb();
        expOut.delete();
        for (int i = 0; i < DL; i++)
            expOut.push_back(LIFO ? mdl[DL-1-i] : mdl[i]);
    endfunction

    function automatic int outsA();
        return int'({AddressTB, RdEn, TBInit, DecodedBit,
                     DecodedValid, Busy, Done});
    endfunction

    task automatic waitIdle(input string nm);
        bit idle;
        idle = 1'b0;
        for (int c = 0; c < 8*TBL && !idle; c++) begin
            @(negedge CLOCK);
            if (!Busy) idle = 1'b1;
        end
        cmp({nm, "_idle"}, int'(idle), 1);
    endtask

    task automatic runTrace(input logic [5:0] st, input bit hold,
                            input string nm);
        int stg, busyCnt, tbi, consec, addrBad, n;
        bit prevRd, doneSeen;
        bit got[$];
        stg = 0; busyCnt = 0; tbi = 0; consec = 0; addrBad = 0;
        prevRd = 1'b0; doneSeen = 1'b0;
        buildModel(int'(st));
        @(negedge CLOCK);
        StartState = st;
        Start = 1'b1;
        for (int c = 0; c < 8*TBL && !doneSeen; c++) begin
            @(negedge CLOCK);
            if (!hold) Start = 1'b0;
            if (Busy) busyCnt++;
            if (TBInit) tbi++;
            if (RdEn) begin
                if (prevRd) consec++;
                if (stg < TBL) begin
                    if (AddressTB != expAddr[stg]) addrBad++;
                    DataTB = surv[stg][AddressTB];
                end
                stg++;
            end
            prevRd = RdEn;
            if (DecodedValid) got.push_back(DecodedBit);
            if (Done) begin
                doneSeen = 1'b1;
                cmp({nm, "_done_with_valid"}, int'(DecodedValid), 1);
            end
        end
        cmp({nm, "_done_seen"}, int'(doneSeen), 1);
        cmp({nm, "_busy_len"}, busyCnt, BUSY_LEN);
        cmp({nm, "_tbinit"}, tbi, 1);
        cmp({nm, "_stages"}, stg, TBL);
        cmp({nm, "_addr_bad"}, addrBad, 0);
        cmp({nm, "_rd_consec"}, consec, 0);
        cmp({nm, "_nbits"}, got.size(), DL);
        n = (got.size() < DL) ? got.size() : DL;
        for (int i = 0; i < n; i++)
            cmp($sformatf("%s_bit%0d", nm, i), int'(got[i]), int'(expOut[i]));
        if (hold) begin
            @(negedge CLOCK);
            cmp({nm, "_restart"}, int'(TBInit && Busy), 1);
            Start = 1'b0;
            waitIdle(nm);
        end
    endtask

    initial begin
        vec_t tbl[6];
        logic [7:0] enc;
        bit u[TBL+6];
        int T, stt, st0, stg, nValid, nBusy;
        int firstV, doneC, nBits, nOnes, addrBad, busyS, dwv;
        bit hit;

        tbl[0] = '{6'h00, 8'h00, 8'h00, 1'b0};
        tbl[1] = '{6'h3F, 8'hFF, 8'hFF, 1'b0};
        tbl[2] = '{6'h3F, 8'h00, 8'h00, 1'b0};
        tbl[3] = '{6'h00, 8'hFF, 8'hFF, 1'b0};
        tbl[4] = '{6'h15, 8'hAA, 8'h55, 1'b0};
        tbl[5] = '{6'h3F, 8'hFF, 8'hFF, 1'b1};

        Start = 1'b0; StartState = '0; DataTB = '0;
        bStart = 1'b0; bStartState = '0; bDataTB = '0;
        repeat (3) @(negedge CLOCK);
        cmp("reset_outs_a", outsA(), 0);
        cmp("reset_outs_b", int'({bAddr, bRdEn, bTBInit, bBit,
                                 bValid, bBusy, bDone}), 0);
        Reset = 1'b0;
        repeat (2) @(negedge CLOCK);
        cmp("post_reset_outs_a", outsA(), 0);

        for (int v = 0; v < 6; v++) begin
            for (int k = 0; k < TBL; k++)
                for (int a = 0; a < 8; a++) surv[k][a] = tbl[v].data;
            DataTB = tbl[v].data;
            mdl.delete();
            for (int i = 0; i < DL; i++) mdl.push_back(tbl[v].expTb[i]);
            orderFromTb();
            runTrace(tbl[v].st, tbl[v].hold, $sformatf("vec%0d", v));
        end

        // Survivor memory built from a known encoder input sequence.
        enc = 8'b1011_0010;
        T = TBL + 5;
        st0 = 0;
        for (int n = 0; n < TBL + 6; n++) u[n] = bit'($urandom % 2);
        for (int i = 0; i < 8; i++) u[6+i] = enc[7-i];
        for (int k = 0; k < TBL; k++) begin
            stt = 0;
            for (int i = 0; i < 6; i++) stt += int'(u[T-k-i]) << i;
            if (k == 0) st0 = stt;
            for (int a = 0; a < 8; a++) surv[k][a] = 8'($urandom);
            surv[k][stt / 8][stt % 8] = u[T-k-6];
        end
        expOut.delete();
        for (int i = 0; i < DL; i++)
            expOut.push_back(LIFO ? enc[7-i] : enc[i]);
        runTrace(6'(st0), 1'b0, "enc");

        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < TBL; k++)
                for (int a = 0; a < 8; a++) surv[k][a] = 8'($urandom);
            stt = int'($urandom_range(0, 63));
            buildModel(stt);
            orderFromTb();
            runTrace(6'(stt), 1'b0, $sformatf("rnd%0d", r));
        end

        // Reset pulse in the middle of a run.
        for (int k = 0; k < TBL; k++)
            for (int a = 0; a < 8; a++) surv[k][a] = 8'($urandom);
        @(negedge CLOCK);
        StartState = 6'h2D;
        Start = 1'b1;
        stg = 0;
        hit = 1'b0;
        for (int c = 0; c < 8*TBL && !hit; c++) begin
            @(negedge CLOCK);
            Start = 1'b0;
            if (RdEn) begin
                DataTB = surv[stg][AddressTB];
                if (stg == 10) hit = 1'b1;
                stg++;
            end
        end
        cmp("rst_reached_stage10", int'(hit), 1);
        Reset = 1'b1;
        @(negedge CLOCK);
        cmp("rst_outs_zero", outsA(), 0);
        Reset = 1'b0;
        nValid = 0;
        nBusy = 0;
        repeat (BUSY_LEN + 10) begin
            @(negedge CLOCK);
            if (DecodedValid) nValid++;
            if (Busy) nBusy++;
        end
        cmp("rst_no_valid", nValid, 0);
        cmp("rst_no_busy", nBusy, 0);

        for (int k = 0; k < TBL; k++)
            for (int a = 0; a < 8; a++) surv[k][a] = 8'($urandom);
        buildModel(6'h2D);
        orderFromTb();
        runTrace(6'h2D, 1'b0, "after_rst");

        // Short configuration: state 01 walks to 00 with zero survivors.
        firstV = -1; doneC = -1; nBits = 0; nOnes = 0;
        addrBad = 0; busyS = 0; dwv = 0;
        @(negedge CLOCK);
        bStartState = 6'h01;
        bStart = 1'b1;
        for (int c = 0; c < 8*TBS && doneC < 0; c++) begin
            @(negedge CLOCK);
            bStart = 1'b0;
            if (bBusy) busyS++;
            if (bRdEn && bAddr != 3'd0) addrBad++;
            if (bValid) begin
                if (firstV < 0) firstV = c;
                nBits++;
                if (bBit) nOnes++;
            end
            if (bDone) begin
                doneC = c;
                dwv = int'(bValid);
            end
        end
        cmp("small_first_valid", firstV, FIRST_V_S);
        cmp("small_done_cycle", doneC, BUSY_S);
        cmp("small_done_with_valid", dwv, 1);
        cmp("small_busy_len", busyS, BUSY_S);
        cmp("small_nbits", nBits, DLS);
        cmp("small_ones", nOnes, 0);
        cmp("small_addr_bad", addrBad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end
endmodule
